// File: rtl/clk_div_prog_if.sv
// Control and status bundle for clk_div_prog: enable, phase restart and divisor
// load go in; divided clock, strobes and divisor status come out.
interface clk_div_prog_if #(
  parameter int CNT_WIDTH = 24
);
  logic                 EN;
  logic                 SYNC_CLR;
  logic [CNT_WIDTH-1:0] DIV_IN;
  logic                 DIV_LOAD;
  logic                 CLKOUT;
  logic                 TICK;
  logic                 PERIOD_TICK;
  logic                 LOAD_PEND;
  logic [CNT_WIDTH-1:0] DIV_ACTIVE;

  modport master (
    output EN, SYNC_CLR, DIV_IN, DIV_LOAD,
    input  CLKOUT, TICK, PERIOD_TICK, LOAD_PEND, DIV_ACTIVE
  );

  modport slave (
    input  EN, SYNC_CLR, DIV_IN, DIV_LOAD,
    output CLKOUT, TICK, PERIOD_TICK, LOAD_PEND, DIV_ACTIVE
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: CLKOUT period 2*(H+1) CLK cycles, TICK on each edge,
// PERIOD_TICK on rises; all outputs registered, first edge H+1 cycles after enable.
module clk_div_prog #(
  parameter int                   CNT_WIDTH   = 24,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIV = 24'd1199999
) (
  input  logic           CLK,
  input  logic           RST,
  clk_div_prog_if.slave  bus
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] div_pend_q, div_pend_d;
  logic [CNT_WIDTH-1:0] div_active_q, div_active_d;
  logic                 clkout_q, clkout_d;
  logic                 tick_q, tick_d;
  logic                 ptick_q, ptick_d;
  logic                 load_pend_q, load_pend_d;
  logic                 term;
  logic                 apply;

  // >= rather than == so a shrinking divisor ends the current half period at once
  assign term = bus.EN && (cnt_q >= div_active_q);

  always_comb begin
    cnt_d        = cnt_q;
    clkout_d     = clkout_q;
    tick_d       = 1'b0;
    ptick_d      = 1'b0;
    div_pend_d   = div_pend_q;
    div_active_d = div_active_q;
    load_pend_d  = load_pend_q;
    apply        = 1'b0;

    if (bus.SYNC_CLR) begin
      cnt_d    = '0;
      clkout_d = 1'b0;
      apply    = 1'b1;
    end else if (bus.EN) begin
      if (term) begin
        cnt_d    = '0;
        clkout_d = ~clkout_q;
        tick_d   = 1'b1;
        ptick_d  = ~clkout_q;
        apply    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      apply = 1'b1;
    end

    if (apply && load_pend_q) begin
      div_active_d = div_pend_q;
      load_pend_d  = 1'b0;
    end

    // A fresh load always wins over the clear from applying the previous value
    if (bus.DIV_LOAD) begin
      div_pend_d  = bus.DIV_IN;
      load_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      clkout_q     <= 1'b0;
      tick_q       <= 1'b0;
      ptick_q      <= 1'b0;
      load_pend_q  <= 1'b0;
      div_active_q <= DEFAULT_DIV;
      div_pend_q   <= DEFAULT_DIV;
    end else begin
      cnt_q        <= cnt_d;
      clkout_q     <= clkout_d;
      tick_q       <= tick_d;
      ptick_q      <= ptick_d;
      load_pend_q  <= load_pend_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
    end
  end

  assign bus.CLKOUT      = clkout_q;
  assign bus.TICK        = tick_q;
  assign bus.PERIOD_TICK = ptick_q;
  assign bus.LOAD_PEND   = load_pend_q;
  assign bus.DIV_ACTIVE  = div_active_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DEFAULT_DIV=2 and an 8-bit counter;
// outputs are sampled 1 time unit after each rising edge, inputs driven there too.
module tb_clk_div_prog;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  clk_div_prog_if #(.CNT_WIDTH(CW)) bus ();

  clk_div_prog #(.CNT_WIDTH(CW), .DEFAULT_DIV(8'd2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic sc, input logic ld, input logic [CW-1:0] din);
    bus.EN       = en;
    bus.SYNC_CLR = sc;
    bus.DIV_LOAD = ld;
    bus.DIV_IN   = din;
  endtask

  logic [11:0] exp_clk, exp_tick, exp_pt;
  logic [5:0]  e2_clk, e2_pt;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    // Reset state
    chk("rst_clkout", bus.CLKOUT, 0);
    chk("rst_tick", bus.TICK, 0);
    chk("rst_ptick", bus.PERIOD_TICK, 0);
    chk("rst_lpend", bus.LOAD_PEND, 0);
    chk("rst_divact", bus.DIV_ACTIVE, 2);

    // H=2: toggles every 3 edges, rises at edges 3 and 9
    rst = 1'b0;
    bus.EN = 1'b1;
    exp_clk  = 12'b0111_0001_1100;
    exp_tick = 12'b1001_0010_0100;
    exp_pt   = 12'b0001_0000_0100;
    for (int e = 0; e < 12; e++) begin
      step();
      chk($sformatf("h2_clk_e%0d", e + 1), bus.CLKOUT, exp_clk[e]);
      chk($sformatf("h2_tick_e%0d", e + 1), bus.TICK, exp_tick[e]);
      chk($sformatf("h2_pt_e%0d", e + 1), bus.PERIOD_TICK, exp_pt[e]);
    end

    // H=0: load via SYNC_CLR, apply on a disabled edge, then CLK/2
    drive(1'b0, 1'b1, 1'b1, 8'd0);
    step();
    chk("h0_ld_lpend", bus.LOAD_PEND, 1);
    chk("h0_ld_divact", bus.DIV_ACTIVE, 2);
    chk("h0_ld_clk", bus.CLKOUT, 0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("h0_app_divact", bus.DIV_ACTIVE, 0);
    chk("h0_app_lpend", bus.LOAD_PEND, 0);
    bus.EN = 1'b1;
    e2_clk = 6'b010101;
    e2_pt  = 6'b010101;
    for (int e = 0; e < 6; e++) begin
      step();
      chk($sformatf("h0_clk_e%0d", e + 1), bus.CLKOUT, e2_clk[e]);
      chk($sformatf("h0_tick_e%0d", e + 1), bus.TICK, 1);
      chk($sformatf("h0_pt_e%0d", e + 1), bus.PERIOD_TICK, e2_pt[e]);
    end

    // H=9 with DIV_LOAD 3 at cnt=2: half period stays 10, then 4
    drive(1'b0, 1'b1, 1'b1, 8'd9);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    chk("h9_divact", bus.DIV_ACTIVE, 9);
    chk("h9_clk0", bus.CLKOUT, 0);
    bus.EN = 1'b1;
    step();
    step();
    bus.DIV_LOAD = 1'b1;
    bus.DIV_IN   = 8'd3;
    step();
    bus.DIV_LOAD = 1'b0;
    chk("h9_ld_lpend", bus.LOAD_PEND, 1);
    chk("h9_ld_divact", bus.DIV_ACTIVE, 9);
    for (int e = 4; e <= 18; e++) begin
      step();
      chk($sformatf("h9_clk_e%0d", e), bus.CLKOUT, ((e >= 10 && e < 14) || e >= 18) ? 1 : 0);
      chk($sformatf("h9_tick_e%0d", e), bus.TICK, (e == 10 || e == 14 || e == 18) ? 1 : 0);
      if (e == 9) chk("h9_divact_e9", bus.DIV_ACTIVE, 9);
      if (e == 10) begin
        chk("h9_divact_e10", bus.DIV_ACTIVE, 3);
        chk("h9_lpend_e10", bus.LOAD_PEND, 0);
        chk("h9_pt_e10", bus.PERIOD_TICK, 1);
      end
    end

    // H=9, run to cnt=7, disable, load 3 while disabled, re-enable
    drive(1'b0, 1'b1, 1'b1, 8'd9);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    bus.EN = 1'b1;
    for (int e = 0; e < 7; e++) step();
    drive(1'b0, 1'b0, 1'b1, 8'd3);
    step();
    bus.DIV_LOAD = 1'b0;
    chk("dis_ld_lpend", bus.LOAD_PEND, 1);
    chk("dis_ld_divact", bus.DIV_ACTIVE, 9);
    step();
    chk("dis_app_divact", bus.DIV_ACTIVE, 3);
    chk("dis_app_lpend", bus.LOAD_PEND, 0);
    for (int e = 0; e < 3; e++) begin
      step();
      chk($sformatf("dis_hold_clk%0d", e), bus.CLKOUT, 0);
      chk($sformatf("dis_hold_tick%0d", e), bus.TICK, 0);
    end
    bus.EN = 1'b1;
    step();
    chk("en_clk", bus.CLKOUT, 1);
    chk("en_tick", bus.TICK, 1);
    chk("en_pt", bus.PERIOD_TICK, 1);

    // DIV_LOAD on the term edge: old pending 5 applied, new 1 stays pending
    bus.DIV_LOAD = 1'b1;
    bus.DIV_IN   = 8'd5;
    step();
    bus.DIV_LOAD = 1'b0;
    chk("tl_e1_lpend", bus.LOAD_PEND, 1);
    chk("tl_e1_divact", bus.DIV_ACTIVE, 3);
    step();
    step();
    chk("tl_e3_clk", bus.CLKOUT, 1);
    bus.DIV_LOAD = 1'b1;
    bus.DIV_IN   = 8'd1;
    step();
    bus.DIV_LOAD = 1'b0;
    chk("tl_e4_clk", bus.CLKOUT, 0);
    chk("tl_e4_tick", bus.TICK, 1);
    chk("tl_e4_divact", bus.DIV_ACTIVE, 5);
    chk("tl_e4_lpend", bus.LOAD_PEND, 1);
    for (int e = 5; e <= 9; e++) step();
    chk("tl_e9_clk", bus.CLKOUT, 0);
    chk("tl_e9_divact", bus.DIV_ACTIVE, 5);
    step();
    chk("tl_e10_clk", bus.CLKOUT, 1);
    chk("tl_e10_pt", bus.PERIOD_TICK, 1);
    chk("tl_e10_divact", bus.DIV_ACTIVE, 1);
    chk("tl_e10_lpend", bus.LOAD_PEND, 0);
    step();
    chk("tl_e11_clk", bus.CLKOUT, 1);
    step();
    chk("tl_e12_clk", bus.CLKOUT, 0);
    chk("tl_e12_tick", bus.TICK, 1);

    // SYNC_CLR together with DIV_LOAD: pending 4 applied, 2 stays pending
    bus.DIV_LOAD = 1'b1;
    bus.DIV_IN   = 8'd4;
    step();
    drive(1'b1, 1'b1, 1'b1, 8'd2);
    step();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    chk("sc_clk", bus.CLKOUT, 0);
    chk("sc_tick", bus.TICK, 0);
    chk("sc_divact", bus.DIV_ACTIVE, 4);
    chk("sc_lpend", bus.LOAD_PEND, 1);
    for (int e = 0; e < 4; e++) step();
    chk("sc_p4_clk", bus.CLKOUT, 0);
    chk("sc_p4_divact", bus.DIV_ACTIVE, 4);
    step();
    chk("sc_p5_clk", bus.CLKOUT, 1);
    chk("sc_p5_pt", bus.PERIOD_TICK, 1);
    chk("sc_p5_divact", bus.DIV_ACTIVE, 2);
    chk("sc_p5_lpend", bus.LOAD_PEND, 0);
    for (int e = 0; e < 3; e++) step();
    chk("sc_p8_clk", bus.CLKOUT, 0);
    chk("sc_p8_tick", bus.TICK, 1);

    // RST mid-period with LOAD_PEND=1 and a DIV_LOAD on the reset edge
    step();
    step();
    bus.DIV_LOAD = 1'b1;
    bus.DIV_IN   = 8'd7;
    step();
    bus.DIV_LOAD = 1'b0;
    chk("pre_rst_clk", bus.CLKOUT, 1);
    chk("pre_rst_lpend", bus.LOAD_PEND, 1);
    step();
    rst = 1'b1;
    bus.DIV_LOAD = 1'b1;
    bus.DIV_IN   = 8'd6;
    step();
    rst = 1'b0;
    bus.DIV_LOAD = 1'b0;
    chk("mrst_clk", bus.CLKOUT, 0);
    chk("mrst_tick", bus.TICK, 0);
    chk("mrst_pt", bus.PERIOD_TICK, 0);
    chk("mrst_lpend", bus.LOAD_PEND, 0);
    chk("mrst_divact", bus.DIV_ACTIVE, 2);
    step();
    step();
    chk("mrst_e2_clk", bus.CLKOUT, 0);
    step();
    chk("mrst_e3_clk", bus.CLKOUT, 1);
    chk("mrst_e3_pt", bus.PERIOD_TICK, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
